// File: rtl/hermes_rx_port_pkg.sv
// Shared types and constants for the Hermes receive port.
// Optional feature macro used by this slice: HERMES_RX_PKT_CNT_EN.
package hermes_pkg;

    localparam int unsigned FLIT_WIDTH = 16;

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        SIZE    = 2'd1,
        PAYLOAD = 2'd2
    } rx_state_t;

    typedef logic [FLIT_WIDTH-1:0] flit_t;

endpackage

// File: rtl/hermes_rx_port_if.sv
// Hermes inbound link (avail/data/credit) plus local valid/ready delivery side.
interface hermes_rx_port_if #(
    parameter int unsigned FLIT_WIDTH = 16
);
    logic                  avail;
    logic [FLIT_WIDTH-1:0] data_in;
    logic                  credit;
    logic                  out_valid;
    logic                  out_ready;
    logic [FLIT_WIDTH-1:0] out_data;
    logic                  out_sop;
    logic                  out_eop;
    logic [FLIT_WIDTH-1:0] out_target;

    // Upstream sender and local consumer combined.
    modport master (
        output avail, data_in, out_ready,
        input  credit, out_valid, out_data, out_sop, out_eop, out_target
    );

    // The receive port itself.
    modport slave (
        input  avail, data_in, out_ready,
        output credit, out_valid, out_data, out_sop, out_eop, out_target
    );
endinterface

// File: rtl/hermes_rx_port_fifo.sv
// Synchronous FIFO used as the receive buffer; head entry is always on rd_data.
module hermes_fifo #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Register update with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/hermes_rx_port.sv
// Hermes router input port: credit-based flit intake, FIFO buffering and
// header/size/payload framing toward a valid/ready consumer.
// Optional macro HERMES_RX_PKT_CNT_EN adds the pkt_count output.
module hermes_rx_port
    import hermes_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH = hermes_pkg::FLIT_WIDTH,
    parameter int unsigned DEPTH      = 4
) (
    input  logic         clock,
    input  logic         reset,
    hermes_rx_port_if.slave rx
`ifdef HERMES_RX_PKT_CNT_EN
    ,
    output logic [15:0]  pkt_count
`endif
);
    localparam logic [1:0] ST_HEADER  = HEADER;
    localparam logic [1:0] ST_SIZE    = SIZE;
    localparam logic [1:0] ST_PAYLOAD = PAYLOAD;
    localparam int unsigned CW        = $clog2(DEPTH) + 1;

    logic [FLIT_WIDTH-1:0] head;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;
    logic                  wr_en;
    logic                  rd_en;

    logic [1:0]            state_q, state_d;
    logic [FLIT_WIDTH-1:0] rem_q, rem_d;
    logic [FLIT_WIDTH-1:0] target_q, target_d;

    hermes_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (rx.data_in),
        .rd_en   (rd_en),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Credit is gated by reset so the sender sees no space while the port is held.
    assign rx.credit     = reset && (count < CW'(DEPTH));
    assign rx.out_valid  = !empty;
    assign rx.out_data   = head;
    assign rx.out_target = target_q;
    assign wr_en         = rx.avail && rx.credit;
    assign rd_en         = rx.out_valid && rx.out_ready;

    assign rx.out_sop = rx.out_valid && (state_q == ST_HEADER);
    assign rx.out_eop = rx.out_valid &&
                        (((state_q == ST_SIZE) && (head == '0)) ||
                         ((state_q == ST_PAYLOAD) && (rem_q == FLIT_WIDTH'(1))));

    // Framing FSM: advances only when the consumer takes the head flit.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        target_d = target_q;
        if (rd_en) begin
            case (state_q)
                ST_HEADER: begin
                    target_d = head;
                    state_d  = ST_SIZE;
                end
                ST_SIZE: begin
                    if (head == '0) begin
                        state_d = ST_HEADER;
                    end else begin
                        rem_d   = head;
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == FLIT_WIDTH'(1)) begin
                        state_d = ST_HEADER;
                    end
                end
                default: state_d = ST_HEADER;
            endcase
        end
    end

    // Framing registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_HEADER;
            rem_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            target_q <= target_d;
        end
    end

`ifdef HERMES_RX_PKT_CNT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    assign pkt_count = pkt_cnt_q;

    // Count delivered packets; wraps naturally at 16 bits.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (rd_en && rx.out_eop) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    // Packet counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_hermes_rx_port.sv
// Self-checking bench for hermes_rx_port: directed vector table, hand-written
// corner sequences, then random traffic against a packet-level reference model.
module tb_hermes_rx_port;
    import hermes_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    hermes_rx_port_if #(.FLIT_WIDTH(16)) bus ();

`ifdef HERMES_RX_PKT_CNT_EN
    logic [15:0] pkt_count;
`endif

    hermes_rx_port #(
        .FLIT_WIDTH (16),
        .DEPTH      (4)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .rx    (bus)
`ifdef HERMES_RX_PKT_CNT_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        avail;
        logic [15:0] din;
        logic        ready;
        logic        e_credit;
        logic        e_valid;
        logic [15:0] e_data;
        logic        e_sop;
        logic        e_eop;
        logic [15:0] e_target;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic a, input logic [15:0] d, input logic r,
                       input logic ec, input logic ev, input logic [15:0] ed,
                       input logic es, input logic ee, input logic [15:0] et);
        vec_t v;
        v.avail = a; v.din = d; v.ready = r;
        v.e_credit = ec; v.e_valid = ev; v.e_data = ed;
        v.e_sop = es; v.e_eop = ee; v.e_target = et;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs at a falling edge and advance across one rising edge.
    task automatic drive(input logic a, input logic [15:0] d, input logic r);
        bus.avail     = a;
        bus.data_in   = d;
        bus.out_ready = r;
        @(negedge clk);
    endtask

    // Reference model state for random traffic.
    flit_t       src[$];
    flit_t       mq[$];
    int unsigned pos;
    int unsigned plen;
    logic [15:0] m_target;
    int unsigned m_pkts;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.avail = 1'b0;
        bus.data_in = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_credit", {15'd0, bus.credit}, 16'd0);
        chk("rst_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("rst_sop", {15'd0, bus.out_sop}, 16'd0);
        chk("rst_eop", {15'd0, bus.out_eop}, 16'd0);
        chk("rst_target", bus.out_target, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_credit", {15'd0, bus.credit}, 16'd1);

        // Single packet with out_ready high.
        add(1, 16'h0011, 1, 1, 0, 16'h0000, 0, 0, 16'h0000);
        add(1, 16'h0002, 1, 1, 1, 16'h0011, 1, 0, 16'h0000);
        add(1, 16'hAAAA, 1, 1, 1, 16'h0002, 0, 0, 16'h0011);
        add(1, 16'hBBBB, 1, 1, 1, 16'hAAAA, 0, 0, 16'h0011);
        add(0, 16'h0000, 1, 1, 1, 16'hBBBB, 0, 1, 16'h0011);
        add(0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 16'h0011);
        // Zero-length packet followed by another header (closed with L=0).
        add(1, 16'h0102, 1, 1, 0, 16'h0000, 0, 0, 16'h0011);
        add(1, 16'h0000, 1, 1, 1, 16'h0102, 1, 0, 16'h0011);
        add(1, 16'h0203, 1, 1, 1, 16'h0000, 0, 1, 16'h0102);
        add(0, 16'h0000, 1, 1, 1, 16'h0203, 1, 0, 16'h0102);
        add(1, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 16'h0203);
        add(0, 16'h0000, 1, 1, 1, 16'h0000, 0, 1, 16'h0203);
        add(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 16'h0203);
        // Backpressure: six offers, only four stored.
        add(1, 16'h0301, 0, 1, 0, 16'h0000, 0, 0, 16'h0203);
        add(1, 16'h0003, 0, 1, 1, 16'h0301, 1, 0, 16'h0203);
        add(1, 16'h0001, 0, 1, 1, 16'h0301, 1, 0, 16'h0203);
        add(1, 16'h0002, 0, 1, 1, 16'h0301, 1, 0, 16'h0203);
        add(1, 16'h0003, 0, 0, 1, 16'h0301, 1, 0, 16'h0203);
        add(1, 16'h0004, 0, 0, 1, 16'h0301, 1, 0, 16'h0203);
        add(0, 16'h0000, 1, 0, 1, 16'h0301, 1, 0, 16'h0203);
        add(0, 16'h0000, 1, 1, 1, 16'h0003, 0, 0, 16'h0301);
        add(0, 16'h0000, 1, 1, 1, 16'h0001, 0, 0, 16'h0301);
        add(0, 16'h0000, 1, 1, 1, 16'h0002, 0, 0, 16'h0301);
        add(1, 16'h0003, 1, 1, 0, 16'h0000, 0, 0, 16'h0301);
        add(0, 16'h0000, 1, 1, 1, 16'h0003, 0, 1, 16'h0301);
        add(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 16'h0301);
        // Full with simultaneous read: write refused, then accepted next cycle.
        add(1, 16'h0401, 0, 1, 0, 16'h0000, 0, 0, 16'h0301);
        add(1, 16'h0002, 0, 1, 1, 16'h0401, 1, 0, 16'h0301);
        add(1, 16'h00A1, 0, 1, 1, 16'h0401, 1, 0, 16'h0301);
        add(1, 16'h00A2, 0, 1, 1, 16'h0401, 1, 0, 16'h0301);
        add(1, 16'h0501, 1, 0, 1, 16'h0401, 1, 0, 16'h0301);
        add(1, 16'h0501, 0, 1, 1, 16'h0002, 0, 0, 16'h0401);
        add(0, 16'h0000, 1, 0, 1, 16'h0002, 0, 0, 16'h0401);
        add(0, 16'h0000, 1, 1, 1, 16'h00A1, 0, 0, 16'h0401);
        add(0, 16'h0000, 1, 1, 1, 16'h00A2, 0, 1, 16'h0401);
        add(0, 16'h0000, 1, 1, 1, 16'h0501, 1, 0, 16'h0401);
        add(1, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 16'h0501);
        add(0, 16'h0000, 1, 1, 1, 16'h0000, 0, 1, 16'h0501);
        add(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 16'h0501);

        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("v%0d_credit", i), {15'd0, bus.credit}, {15'd0, tbl[i].e_credit});
            chk($sformatf("v%0d_valid", i), {15'd0, bus.out_valid}, {15'd0, tbl[i].e_valid});
            if (tbl[i].e_valid)
                chk($sformatf("v%0d_data", i), bus.out_data, tbl[i].e_data);
            chk($sformatf("v%0d_sop", i), {15'd0, bus.out_sop}, {15'd0, tbl[i].e_sop});
            chk($sformatf("v%0d_eop", i), {15'd0, bus.out_eop}, {15'd0, tbl[i].e_eop});
            chk($sformatf("v%0d_target", i), bus.out_target, tbl[i].e_target);
            drive(tbl[i].avail, tbl[i].din, tbl[i].ready);
        end

`ifdef HERMES_RX_PKT_CNT_EN
        chk("pkt_count_after_table", pkt_count, 16'd6);
        force dut.pkt_cnt_q = 16'hFFFF;
        drive(0, 16'h0000, 0);
        release dut.pkt_cnt_q;
        chk("pkt_count_forced", pkt_count, 16'hFFFF);
        drive(1, 16'h0701, 1);
        drive(1, 16'h0000, 1);
        drive(0, 16'h0000, 1);
        chk("pkt_count_wrap", pkt_count, 16'h0000);
`endif

        // Reset in the middle of a buffered packet.
        drive(1, 16'h0601, 0);
        drive(1, 16'h0003, 0);
        drive(1, 16'h00B1, 0);
        chk("mid_valid", {15'd0, bus.out_valid}, 16'd1);
        chk("mid_data", bus.out_data, 16'h0601);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("mid_rst_credit", {15'd0, bus.credit}, 16'd0);
        chk("mid_rst_sop", {15'd0, bus.out_sop}, 16'd0);
        chk("mid_rst_target", bus.out_target, 16'h0000);
        drive(1, 16'h00B2, 0);
        chk("mid_rst_credit_hold", {15'd0, bus.credit}, 16'd0);
        chk("mid_rst_valid_hold", {15'd0, bus.out_valid}, 16'd0);
        rst_n = 1'b1;
        drive(0, 16'h0000, 0);
        chk("after_rst_credit", {15'd0, bus.credit}, 16'd1);
        chk("after_rst_valid", {15'd0, bus.out_valid}, 16'd0);
        drive(1, 16'h0044, 0);
        chk("after_rst_data", bus.out_data, 16'h0044);
        chk("after_rst_sop", {15'd0, bus.out_sop}, 16'd1);
        chk("after_rst_eop", {15'd0, bus.out_eop}, 16'd0);
        drive(1, 16'h0000, 1);
        chk("after_rst_size", bus.out_data, 16'h0000);
        chk("after_rst_size_eop", {15'd0, bus.out_eop}, 16'd1);
        chk("after_rst_target", bus.out_target, 16'h0044);
        drive(0, 16'h0000, 1);
        chk("after_rst_empty", {15'd0, bus.out_valid}, 16'd0);
`ifdef HERMES_RX_PKT_CNT_EN
        chk("pkt_count_after_rst", pkt_count, 16'd1);
`endif

        // Random traffic against a packet-level model.
        rst_n = 1'b0;
        drive(0, 16'h0000, 0);
        rst_n = 1'b1;
        drive(0, 16'h0000, 0);
        for (int p = 0; p < 25; p++) begin
            int unsigned len;
            len = $urandom_range(0, 5);
            src.push_back(flit_t'($urandom));
            src.push_back(flit_t'(len));
            for (int k = 0; k < int'(len); k++) src.push_back(flit_t'($urandom));
        end
        mq.delete();
        pos = 0;
        plen = 0;
        m_target = '0;
        m_pkts = 0;
        begin
            int cyc;
            cyc = 0;
            while ((src.size() > 0 || mq.size() > 0) && cyc < 3000) begin
                logic        a, r, exp_credit, exp_valid, exp_sop, exp_eop;
                logic [15:0] d;
                exp_credit = (mq.size() < 4);
                exp_valid  = (mq.size() > 0);
                exp_sop    = exp_valid && (pos == 0);
                exp_eop    = exp_valid &&
                             ((pos == 1 && mq[0] == 16'h0000) ||
                              (pos >= 2 && pos == plen + 1));
                chk("rnd_credit", {15'd0, bus.credit}, {15'd0, exp_credit});
                chk("rnd_valid", {15'd0, bus.out_valid}, {15'd0, exp_valid});
                if (exp_valid) chk("rnd_data", bus.out_data, mq[0]);
                chk("rnd_sop", {15'd0, bus.out_sop}, {15'd0, exp_sop});
                chk("rnd_eop", {15'd0, bus.out_eop}, {15'd0, exp_eop});
                chk("rnd_target", bus.out_target, m_target);

                a = (src.size() > 0) && ($urandom_range(0, 3) != 0);
                d = (src.size() > 0) ? src[0] : 16'h0000;
                r = ($urandom_range(0, 2) != 0);

                if (exp_valid && r) begin
                    flit_t h;
                    h = mq.pop_front();
                    if (exp_eop) m_pkts++;
                    if (pos == 0) begin
                        m_target = h;
                        pos = 1;
                    end else if (pos == 1) begin
                        plen = h;
                        pos = (h == 0) ? 0 : 2;
                    end else if (pos == plen + 1) begin
                        pos = 0;
                    end else begin
                        pos++;
                    end
                end
                if (a && exp_credit) begin
                    mq.push_back(src.pop_front());
                end
                drive(a, d, r);
                cyc++;
            end
            chk("rnd_timeout", {15'd0, (src.size() > 0 || mq.size() > 0)}, 16'd0);
        end
`ifdef HERMES_RX_PKT_CNT_EN
        chk("rnd_pkt_count", pkt_count, 16'(m_pkts));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
